// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, register map, status bits.
// Shared by the transmitter and receiver peripherals.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam logic [1:0] UART_RX_DATA = 2'd0;
  localparam logic [1:0] UART_RX_STAT = 2'd1;
  localparam logic [1:0] UART_RX_POP  = 2'd2;
  localparam logic [1:0] UART_RX_CLR  = 2'd3;

  localparam int STAT_VALID = 0;
  localparam int STAT_FERR  = 1;
  localparam int STAT_OVR   = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; a push while full is accepted only if a pop
// frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    head,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign level   = wp - rp;
  assign empty   = (wp == rp);
  assign full    = (level == PW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_simp_bus.sv
// 8N1 UART receiver with FIFO and a 4-byte register window
// on the simple external bus.
module uart_rx_simp_bus
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic [7:0] dout,
  input  logic       rx_p,
  output logic       rx_irq
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  logic          rx_m, rx_s;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    sh, sh_n;
  logic          push, ferr_set;
  logic          overrun, frame_err;
  logic          pop_req, pop_ok, ovr_set;
  logic          clr_wr;
  logic [7:0]    head;
  logic          empty, full;
  logic [PW-1:0] level;
  logic [PW-1:0] level_n;
  logic          unused_din;

  assign unused_din = ^din[7:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_p;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      sh     <= sh_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
    bitcnt_n = bitcnt;
    sh_n     = sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          cnt_n    = HALF;
          bitcnt_n = '0;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n   = FULL;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          sh_n     = {rx_s, sh[7:1]};
          cnt_n    = FULL;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          push     = rx_s;
          ferr_set = !rx_s;
          state_n  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop_req = wr_en && (adr == UART_RX_POP);
  assign clr_wr  = wr_en && (adr == UART_RX_CLR);
  assign pop_ok  = pop_req && !empty;
  assign ovr_set = push && full && !pop_ok;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop_req),
    .wdata (sh),
    .head  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  // Occupancy after this edge, so rx_irq tracks the FIFO with no lag
  always_comb begin
    level_n = level;
    if (push && (!full || pop_ok)) level_n = level_n + 1'b1;
    if (pop_ok) level_n = level_n - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      if (ovr_set) overrun <= 1'b1;
      else if (clr_wr && din[0]) overrun <= 1'b0;
      if (ferr_set) frame_err <= 1'b1;
      else if (clr_wr && din[1]) frame_err <= 1'b0;
      rx_irq <= (level_n != '0);
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (adr)
      UART_RX_DATA: dout = empty ? 8'h00 : head;
      UART_RX_STAT: dout = {5'b0, overrun, frame_err, !empty};
      UART_RX_POP:  dout = 8'h00;
      UART_RX_CLR:  dout = 8'h00;
      default:      dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_simp_bus.sv
// Self-checking bench for uart_rx_simp_bus at CPB=16: frame table,
// FIFO scoreboard, overrun, pop-on-stop, glitch and mid-frame reset.
module tb_uart_rx_simp_bus;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] adr = 2'd0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] dout;
  logic       rx_p = 1'b1;
  logic       rx_irq;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] exp_q [$];
  bit         exp_ovr = 1'b0;
  bit         exp_ferr = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         hold;
    logic [7:0] stat;
    logic [7:0] head;
    bit         irq;
  } vec_t;

  vec_t vecs [4];

  uart_rx_simp_bus #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .adr    (adr),
    .din    (din),
    .wr_en  (wr_en),
    .dout   (dout),
    .rx_p   (rx_p),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    adr = a;
    #1;
    v = dout;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    adr = a;
    din = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    din = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_stat();
    return {5'b0, exp_ovr, exp_ferr, exp_q.size() != 0};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() < 4) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int hold);
    rx_p = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_p = b[i];
      cycles(CPB);
    end
    rx_p = stop_ok;
    cycles(CPB);
    if (!stop_ok) begin
      cycles(hold);
      rx_p = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    logic [7:0] v;
    while (exp_q.size() != 0) begin
      rd(UART_RX_DATA, v);
      chk(name, v, exp_q.pop_front());
      wr(UART_RX_POP, 8'h00);
    end
    rd(UART_RX_DATA, v);
    chk({name, "_empty"}, v, 8'h00);
  endtask

  initial begin
    logic [7:0] v;

    vecs[0] = '{8'hA5, 1'b1, 0,  8'h01, 8'hA5, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 40, 8'h02, 8'h00, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 0,  8'h03, 8'h11, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 0,  8'h03, 8'h00, 1'b1};

    cycles(3);
    rd(UART_RX_STAT, v); chk("rst_stat", v, 8'h00);
    rd(UART_RX_DATA, v); chk("rst_data", v, 8'h00);
    chk("rst_irq", {7'b0, rx_irq}, 8'h00);
    rst = 1'b0;
    cycles(4);
    rd(UART_RX_POP, v); chk("rd_adr2", v, 8'h00);
    rd(UART_RX_CLR, v); chk("rd_adr3", v, 8'h00);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].hold);
      if (vecs[i].stop_ok) model_push(vecs[i].data);
      else exp_ferr = 1'b1;
      cycles(20);
      rd(UART_RX_STAT, v); chk($sformatf("vec%0d_stat", i), v, vecs[i].stat);
      chk($sformatf("vec%0d_model", i), v, model_stat());
      rd(UART_RX_DATA, v); chk($sformatf("vec%0d_head", i), v, vecs[i].head);
      chk($sformatf("vec%0d_irq", i), {7'b0, rx_irq}, {7'b0, vecs[i].irq});
      drain($sformatf("vec%0d_pop", i));
      rd(UART_RX_STAT, v); chk($sformatf("vec%0d_after", i), v, model_stat());
    end

    wr(UART_RX_CLR, 8'h00);
    rd(UART_RX_STAT, v); chk("clr_zero_keeps", v, 8'h02);
    wr(UART_RX_CLR, 8'h02);
    exp_ferr = 1'b0;
    rd(UART_RX_STAT, v); chk("clr_ferr", v, 8'h00);

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
      model_push(8'(i));
    end
    cycles(10);
    rd(UART_RX_STAT, v); chk("ovr_stat", v, 8'h05);
    chk("ovr_model", v, model_stat());
    chk("ovr_irq", {7'b0, rx_irq}, 8'h01);

    wr(UART_RX_CLR, 8'h01);
    exp_ovr = 1'b0;
    rd(UART_RX_STAT, v); chk("clr_ovr", v, 8'h01);

    // Pop lands on the same edge as the stop-bit sample of 8'h77
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        cycles(154);
        adr = UART_RX_POP;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(8'h77);
    cycles(10);
    rd(UART_RX_STAT, v); chk("popstop_stat", v, 8'h01);
    drain("popstop_pop");
    rd(UART_RX_STAT, v); chk("popstop_after", v, 8'h00);
    chk("popstop_irq", {7'b0, rx_irq}, 8'h00);

    rx_p = 1'b0;
    cycles(4);
    rx_p = 1'b1;
    cycles(40);
    rd(UART_RX_STAT, v); chk("glitch_stat", v, 8'h00);
    chk("glitch_state", 8'(dut.state), 8'(IDLE));

    send_frame(8'h99, 1'b1, 0);
    model_push(8'h99);
    cycles(5);
    rx_p = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_p = i[0];
      cycles(CPB);
    end
    rx_p = 1'b0;
    cycles(8);
    rst = 1'b1;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_ferr = 1'b0;
    #1;
    rd(UART_RX_STAT, v); chk("mrst_stat", v, 8'h00);
    rd(UART_RX_DATA, v); chk("mrst_data", v, 8'h00);
    chk("mrst_irq", {7'b0, rx_irq}, 8'h00);
    cycles(2);
    rst = 1'b0;
    rx_p = 1'b1;
    cycles(40);
    send_frame(8'h5A, 1'b1, 0);
    model_push(8'h5A);
    cycles(10);
    rd(UART_RX_STAT, v); chk("mrst_rx_stat", v, 8'h01);
    drain("mrst_rx_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
